// File: rtl/bram_byte_port_arbiter.sv
// Two-requester front end for a byte-mode BlockRAM_1KB tile. Read and write
// ports arbitrate independently (round-robin each) and read bytes return at fixed latency.
module bram_byte_port_arbiter #(
   parameter bit OUT_REG = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        a_req_valid,
   output logic        a_req_ready,
   input  logic        a_req_we,
   input  logic [9:0]  a_req_addr,
   input  logic [7:0]  a_req_wdata,
   output logic        a_rsp_valid,
   output logic [7:0]  a_rsp_rdata,

   input  logic        b_req_valid,
   output logic        b_req_ready,
   input  logic        b_req_we,
   input  logic [9:0]  b_req_addr,
   input  logic [7:0]  b_req_wdata,
   output logic        b_rsp_valid,
   output logic [7:0]  b_rsp_rdata,

   output logic [7:0]  bram_rd_addr,
   output logic [7:0]  bram_wr_addr,
   output logic [31:0] bram_wr_data,
   input  logic [31:0] bram_rd_data,

   output logic        bram_c0,
   output logic        bram_c1,
   output logic        bram_c2,
   output logic        bram_c3,
   output logic        bram_c4,
   output logic        bram_c5
);

   localparam int LAT = 1 + int'(OUT_REG);

   logic           a_rd, b_rd, a_wr, b_wr;
   logic           rd_ptr, wr_ptr;
   logic           rd_gnt_a, rd_gnt_b, wr_gnt_a, wr_gnt_b;
   logic           rd_any, wr_any, collide, rd_issue;
   logic [9:0]     rd_addr, wr_addr;
   logic [7:0]     wr_byte;
   logic [LAT-1:0] pipe_valid;
   logic [LAT-1:0] pipe_id;
   logic           rsp_live, rsp_is_b;
   logic           unused_rd_upper;

   // Candidates are gated by rst_n so nothing is granted or driven to the tile in reset.
   assign a_rd = rst_n & a_req_valid & ~a_req_we;
   assign b_rd = rst_n & b_req_valid & ~b_req_we;
   assign a_wr = rst_n & a_req_valid &  a_req_we;
   assign b_wr = rst_n & b_req_valid &  b_req_we;

   assign rd_gnt_a = a_rd & (~b_rd | ~rd_ptr);
   assign rd_gnt_b = b_rd & (~a_rd |  rd_ptr);
   assign wr_gnt_a = a_wr & (~b_wr | ~wr_ptr);
   assign wr_gnt_b = b_wr & (~a_wr |  wr_ptr);

   assign rd_any  = rd_gnt_a | rd_gnt_b;
   assign wr_any  = wr_gnt_a | wr_gnt_b;
   assign rd_addr = rd_gnt_b ? b_req_addr : a_req_addr;
   assign wr_addr = wr_gnt_b ? b_req_addr : a_req_addr;
   assign wr_byte = wr_gnt_b ? b_req_wdata : a_req_wdata;

   // A same-address read is held back one cycle so it observes the byte being written now.
   assign collide  = rd_any & wr_any & (rd_addr == wr_addr);
   assign rd_issue = rd_any & ~collide;

   assign a_req_ready = (rd_gnt_a & ~collide) | wr_gnt_a;
   assign b_req_ready = (rd_gnt_b & ~collide) | wr_gnt_b;

   assign bram_rd_addr = rd_issue ? rd_addr[7:0] : 8'h00;
   assign bram_wr_addr = wr_any   ? wr_addr[7:0] : 8'h00;
   assign bram_wr_data = {6'b0,
                          (rd_issue ? rd_addr[9:8] : 2'b00),
                          3'b0,
                          wr_any,
                          2'b0,
                          (wr_any ? wr_addr[9:8] : 2'b00),
                          8'b0,
                          (wr_any ? wr_byte : 8'h00)};

   assign bram_c0 = 1'b1;
   assign bram_c1 = 1'b0;
   assign bram_c2 = 1'b1;
   assign bram_c3 = 1'b0;
   assign bram_c4 = 1'b0;
   assign bram_c5 = OUT_REG;

   // Round-robin pointers move to the loser only when their port actually issues.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (rd_issue) rd_ptr <= rd_gnt_a;
         if (wr_any)   wr_ptr <= wr_gnt_a;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_valid <= '0;
         pipe_id    <= '0;
      end else begin
         pipe_valid[0] <= rd_issue;
         pipe_id[0]    <= rd_gnt_b;
         for (int i = 1; i < LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_id[i]    <= pipe_id[i-1];
         end
      end
   end

   assign rsp_live = pipe_valid[LAT-1];
   assign rsp_is_b = pipe_id[LAT-1];

   assign a_rsp_valid = rsp_live & ~rsp_is_b;
   assign b_rsp_valid = rsp_live &  rsp_is_b;
   assign a_rsp_rdata = a_rsp_valid ? bram_rd_data[7:0] : 8'h00;
   assign b_rsp_rdata = b_rsp_valid ? bram_rd_data[7:0] : 8'h00;

   assign unused_rd_upper = ^bram_rd_data[31:8];

endmodule

// File: tb/tb_bram_byte_port_arbiter.sv
// Bench for bram_byte_port_arbiter: drives one stimulus into an OUT_REG=0 and an OUT_REG=1
// instance, each with its own tile model, and checks both against a rule-level model.
module tb_bram_byte_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       a_req_valid = 1'b0, a_req_we = 1'b0;
   logic [9:0] a_req_addr = '0;
   logic [7:0] a_req_wdata = '0;
   logic       b_req_valid = 1'b0, b_req_we = 1'b0;
   logic [9:0] b_req_addr = '0;
   logic [7:0] b_req_wdata = '0;

   logic        a_rdy0, b_rdy0, a_rv0, b_rv0;
   logic [7:0]  a_rdat0, b_rdat0, rda0, wra0;
   logic [31:0] wrd0, rdd0;
   logic [5:0]  cp0;
   logic        a_rdy1, b_rdy1, a_rv1, b_rv1;
   logic [7:0]  a_rdat1, b_rdat1, rda1, wra1;
   logic [31:0] wrd1, rdd1;
   logic [5:0]  cp1;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bram_byte_port_arbiter #(.OUT_REG(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_rdy0), .a_req_we(a_req_we),
      .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
      .a_rsp_valid(a_rv0), .a_rsp_rdata(a_rdat0),
      .b_req_valid(b_req_valid), .b_req_ready(b_rdy0), .b_req_we(b_req_we),
      .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
      .b_rsp_valid(b_rv0), .b_rsp_rdata(b_rdat0),
      .bram_rd_addr(rda0), .bram_wr_addr(wra0), .bram_wr_data(wrd0), .bram_rd_data(rdd0),
      .bram_c0(cp0[0]), .bram_c1(cp0[1]), .bram_c2(cp0[2]),
      .bram_c3(cp0[3]), .bram_c4(cp0[4]), .bram_c5(cp0[5]));

   bram_byte_port_arbiter #(.OUT_REG(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_rdy1), .a_req_we(a_req_we),
      .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
      .a_rsp_valid(a_rv1), .a_rsp_rdata(a_rdat1),
      .b_req_valid(b_req_valid), .b_req_ready(b_rdy1), .b_req_we(b_req_we),
      .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
      .b_rsp_valid(b_rv1), .b_rsp_rdata(b_rdat1),
      .bram_rd_addr(rda1), .bram_wr_addr(wra1), .bram_wr_data(wrd1), .bram_rd_data(rdd1),
      .bram_c0(cp1[0]), .bram_c1(cp1[1]), .bram_c2(cp1[2]),
      .bram_c3(cp1[3]), .bram_c4(cp1[4]), .bram_c5(cp1[5]));

   // Byte-mode tile models: 10-bit address is {field bits, port address}; junk in the upper read bits.
   logic [7:0] mem0 [1024];
   logic [7:0] mem1 [1024];
   logic [7:0] rq0, rq1a, rq1b;

   always @(posedge clk) begin
      if (wrd0[20]) mem0[{wrd0[17:16], wra0}] <= wrd0[7:0];
      rq0 <= mem0[{wrd0[25:24], rda0}];
   end
   assign rdd0 = {24'hDEADBE, rq0};

   always @(posedge clk) begin
      if (wrd1[20]) mem1[{wrd1[17:16], wra1}] <= wrd1[7:0];
      rq1a <= mem1[{wrd1[25:24], rda1}];
      rq1b <= rq1a;
   end
   assign rdd1 = {24'hBEEF55, rq1b};

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   // Rule-level model: reference memory, preferred requester per port, and responses by due cycle.
   logic [7:0] ref_mem [1024];
   int         rd_pref = 0;
   int         wr_pref = 0;
   bit         exp_v  [2][2048];
   int         exp_id [2][2048];
   logic [7:0] exp_d  [2][2048];

   always @(negedge clk) begin
      int         r_sel, w_sel, nr, nw, e_wd;
      bit         ar, br, aw, bw, e_av, e_bv;
      logic [9:0] r_addr, w_addr;
      logic [7:0] w_byte, e_ad, e_bd;

      if (!rst_n)
         for (int i = cyc; i < 2048; i++) begin
            exp_v[0][i] = 1'b0;
            exp_v[1][i] = 1'b0;
         end

      r_sel = -1; w_sel = -1; r_addr = '0; w_addr = '0; w_byte = '0;
      if (rst_n) begin
         ar = a_req_valid && !a_req_we;  br = b_req_valid && !b_req_we;
         aw = a_req_valid &&  a_req_we;  bw = b_req_valid &&  b_req_we;
         nr = int'(ar) + int'(br);
         nw = int'(aw) + int'(bw);
         if (nr == 2) r_sel = rd_pref; else if (ar) r_sel = 0; else if (br) r_sel = 1;
         if (nw == 2) w_sel = wr_pref; else if (aw) w_sel = 0; else if (bw) w_sel = 1;
         if (r_sel >= 0) r_addr = (r_sel == 1) ? b_req_addr : a_req_addr;
         if (w_sel >= 0) begin
            w_addr = (w_sel == 1) ? b_req_addr : a_req_addr;
            w_byte = (w_sel == 1) ? b_req_wdata : a_req_wdata;
         end
         if (r_sel >= 0 && w_sel >= 0 && r_addr == w_addr) r_sel = -1;
      end

      e_wd = 0;
      if (w_sel >= 0) e_wd = int'(w_byte) + 65536 * (int'(w_addr) / 256) + 1048576;
      if (r_sel >= 0) e_wd = e_wd + 16777216 * (int'(r_addr) / 256);

      check_output("a_ready0", a_rdy0, (r_sel == 0 || w_sel == 0));
      check_output("b_ready0", b_rdy0, (r_sel == 1 || w_sel == 1));
      check_output("a_ready1", a_rdy1, (r_sel == 0 || w_sel == 0));
      check_output("b_ready1", b_rdy1, (r_sel == 1 || w_sel == 1));
      check_output("rd_addr0", rda0, (r_sel >= 0) ? int'(r_addr) % 256 : 0);
      check_output("wr_addr0", wra0, (w_sel >= 0) ? int'(w_addr) % 256 : 0);
      check_output("wr_data0", wrd0, e_wd);
      check_output("rd_addr1", rda1, (r_sel >= 0) ? int'(r_addr) % 256 : 0);
      check_output("wr_addr1", wra1, (w_sel >= 0) ? int'(w_addr) % 256 : 0);
      check_output("wr_data1", wrd1, e_wd);
      check_output("cfg0", cp0, 6'b000101);
      check_output("cfg1", cp1, 6'b100101);

      e_av = exp_v[0][cyc] && exp_id[0][cyc] == 0;
      e_bv = exp_v[0][cyc] && exp_id[0][cyc] == 1;
      e_ad = e_av ? exp_d[0][cyc] : 8'h00;
      e_bd = e_bv ? exp_d[0][cyc] : 8'h00;
      check_output("a_rsp_valid0", a_rv0, e_av);
      check_output("b_rsp_valid0", b_rv0, e_bv);
      check_output("a_rsp_rdata0", a_rdat0, e_ad);
      check_output("b_rsp_rdata0", b_rdat0, e_bd);

      e_av = exp_v[1][cyc] && exp_id[1][cyc] == 0;
      e_bv = exp_v[1][cyc] && exp_id[1][cyc] == 1;
      e_ad = e_av ? exp_d[1][cyc] : 8'h00;
      e_bd = e_bv ? exp_d[1][cyc] : 8'h00;
      check_output("a_rsp_valid1", a_rv1, e_av);
      check_output("b_rsp_valid1", b_rv1, e_bv);
      check_output("a_rsp_rdata1", a_rdat1, e_ad);
      check_output("b_rsp_rdata1", b_rdat1, e_bd);

      if (rst_n) begin
         if (r_sel >= 0) begin
            rd_pref = 1 - r_sel;
            exp_v[0][cyc+1] = 1'b1; exp_id[0][cyc+1] = r_sel; exp_d[0][cyc+1] = ref_mem[r_addr];
            exp_v[1][cyc+2] = 1'b1; exp_id[1][cyc+2] = r_sel; exp_d[1][cyc+2] = ref_mem[r_addr];
         end
         if (w_sel >= 0) begin
            ref_mem[w_addr] = w_byte;
            wr_pref = 1 - w_sel;
         end
      end else begin
         rd_pref = 0;
         wr_pref = 0;
      end
   end

   always @(posedge clk) begin
      if (cyc > 1500) begin
         total++;
         bad++;
         $display("[TB] FAIL watchdog cyc=%0d got=running want=finished", cyc);
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   task automatic apply_stimulus(input bit av, input bit aw, input logic [9:0] aa, input logic [7:0] ad,
                                 input bit bv, input bit bw, input logic [9:0] ba, input logic [7:0] bd);
      @(posedge clk);
      #1;
      a_req_valid = av; a_req_we = aw; a_req_addr = aa; a_req_wdata = ad;
      b_req_valid = bv; b_req_we = bw; b_req_addr = ba; b_req_wdata = bd;
      @(negedge clk);
   endtask

   task automatic idle_cycle();
      apply_stimulus(0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00);
   endtask

   // Requests stay asserted through reset so the gating of ready and the tile write enable is visible.
   task automatic pulse_reset(input int n);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 10'h001;
      b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 10'h2FF; b_req_wdata = 8'hEE;
      repeat (n) begin
         @(negedge clk);
         check_output("rst_a_ready", a_rdy0, 0);
         check_output("rst_b_ready", b_rdy0, 0);
         check_output("rst_wr_data", wrd0, 0);
         check_output("rst_a_rsp", a_rv0, 0);
      end
      @(posedge clk);
      #1;
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      pulse_reset(3);

      // Preload bytes used later; both write at once so the write port arbitrates A then B.
      apply_stimulus(1, 1, 10'h001, 8'h3D, 1, 1, 10'h2FF, 8'hC3);
      check_output("wwin_a", a_rdy0, 1);
      check_output("wwin_b", b_rdy0, 0);
      apply_stimulus(0, 0, 10'h000, 8'h00, 1, 1, 10'h2FF, 8'hC3);
      check_output("wnext_b", b_rdy0, 1);
      apply_stimulus(1, 1, 10'h200, 8'h99, 0, 0, 10'h000, 8'h00);

      // Read contention: grants A,B,A,B; responses follow one and two cycles later.
      for (int i = 0; i < 6; i++) begin
         if (i < 4) apply_stimulus(1, 0, 10'h001, 8'h00, 1, 0, 10'h2FF, 8'h00);
         else       idle_cycle();
         if (i < 4) begin
            check_output("cont_a_ready", a_rdy0, (i % 2 == 0));
            check_output("cont_b_ready", b_rdy0, (i % 2 == 1));
         end
         if (i >= 1 && i <= 4) begin
            if ((i - 1) % 2 == 0) check_output("cont_a_rsp0", {a_rv0, a_rdat0}, 9'h13D);
            else                  check_output("cont_b_rsp0", {b_rv0, b_rdat0}, 9'h1C3);
         end
         if (i >= 2) begin
            if ((i - 2) % 2 == 0) check_output("cont_a_rsp1", {a_rv1, a_rdat1}, 9'h13D);
            else                  check_output("cont_b_rsp1", {b_rv1, b_rdat1}, 9'h1C3);
         end
      end

      // Single read after write.
      apply_stimulus(1, 1, 10'h3C1, 8'h5A, 0, 0, 10'h000, 8'h00);
      check_output("raw_wr_data", wrd0, 32'h0013_005A);
      check_output("raw_wr_addr", wra0, 8'hC1);
      apply_stimulus(1, 0, 10'h3C1, 8'h00, 0, 0, 10'h000, 8'h00);
      check_output("raw_rd_addr", rda0, 8'hC1);
      check_output("raw_rd_field", wrd0, 32'h0300_0000);
      idle_cycle();
      check_output("raw_rsp0", {a_rv0, a_rdat0}, 9'h15A);
      check_output("raw_rsp1_early", a_rv1, 0);
      idle_cycle();
      check_output("raw_rsp1", {a_rv1, a_rdat1}, 9'h15A);

      // Concurrent write by A and read by B.
      apply_stimulus(1, 1, 10'h100, 8'hAA, 1, 0, 10'h200, 8'h00);
      check_output("conc_a_ready", a_rdy0, 1);
      check_output("conc_b_ready", b_rdy0, 1);
      check_output("conc_wr_data", wrd0, 32'h0211_00AA);
      idle_cycle();
      check_output("conc_b_rsp0", {b_rv0, b_rdat0}, 9'h199);
      idle_cycle();

      // Same-address collision: the read waits one cycle and sees the new byte.
      apply_stimulus(1, 1, 10'h0FF, 8'h77, 1, 0, 10'h0FF, 8'h00);
      check_output("coll_a_ready", a_rdy0, 1);
      check_output("coll_b_ready", b_rdy0, 0);
      check_output("coll_wr_data", wrd0, 32'h0010_0077);
      apply_stimulus(0, 0, 10'h000, 8'h00, 1, 0, 10'h0FF, 8'h00);
      check_output("coll_b_retry", b_rdy0, 1);
      idle_cycle();
      check_output("coll_b_rsp0", {b_rv0, b_rdat0}, 9'h177);
      idle_cycle();

      // Lane packing sweep over the four upper-address values.
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1, 1, 10'(k * 256 + 5), 8'(16 + k), 0, 0, 10'h000, 8'h00);
         check_output("lane_wr_data", wrd0, 32'h0010_0010 + 32'(k) * 32'h0001_0001);
      end
      for (int k = 0; k < 5; k++) begin
         if (k < 4) apply_stimulus(0, 0, 10'h000, 8'h00, 1, 0, 10'(k * 256 + 5), 8'h00);
         else       idle_cycle();
         if (k < 4) check_output("lane_rd_field", wrd0, 32'(k) << 24);
         if (k > 0) check_output("lane_rsp0", {b_rv0, b_rdat0}, 9'h100 + 9'(16 + k - 1));
      end
      idle_cycle();

      // Reset with a read in flight; afterwards A must win the first contention again.
      apply_stimulus(1, 0, 10'h001, 8'h00, 0, 0, 10'h000, 8'h00);
      check_output("inflight_a_ready", a_rdy0, 1);
      pulse_reset(3);
      apply_stimulus(1, 0, 10'h001, 8'h00, 1, 0, 10'h2FF, 8'h00);
      check_output("post_rst_a_ready", a_rdy0, 1);
      check_output("post_rst_b_ready", b_rdy0, 0);
      idle_cycle();
      idle_cycle();
      idle_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
